// File: rtl/alu_pkg.sv
// Shared ALU definitions: control code width and operation encodings.
// Used by decode logic and by the ALU arbiter.
package alu_pkg;

    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD = 4'd0;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'd1;
    localparam logic [CTRL_W-1:0] ALU_AND = 4'd2;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'd3;
    localparam logic [CTRL_W-1:0] ALU_NOR = 4'd4;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'd5;
    localparam logic [CTRL_W-1:0] ALU_LAST_OP = 4'd5;

    function automatic logic is_bad_op(input logic [CTRL_W-1:0] ctrl);
        return ctrl > ALU_LAST_OP;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add/sub wrap, bitwise ops, unsigned set-less-than.
// Unknown control codes produce zero.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [alu_pkg::CTRL_W-1:0] ctrl,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic [WIDTH-1:0]           y
);
    import alu_pkg::*;

    always_comb begin
        y = '0;
        case (ctrl)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_NOR: y = ~(a | b);
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, (a < b)};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the port that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration and
// a registered, individually backpressured result per port.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_err
);
    import alu_pkg::*;

    logic             last_grant_q, last_grant_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic             rsp0_err_q, rsp0_err_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic             rsp1_err_q, rsp1_err_d;

    logic [1:0]        elig;
    logic [1:0]        grant;
    logic              sel;
    logic [CTRL_W-1:0] sel_ctrl;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [WIDTH-1:0]  alu_y;
    logic              sel_bad;
    logic [WIDTH-1:0]  acc_result;

    // A slot is free if empty or being drained this same cycle; nothing is granted in reset.
    assign elig[0] = !rst && req0_valid && (!rsp0_valid_q || rsp0_ready);
    assign elig[1] = !rst && req1_valid && (!rsp1_valid_q || rsp1_ready);

    rr_arb2 u_arb (
        .elig       (elig),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign sel      = grant[1];
    assign sel_ctrl = sel ? req1_ctrl : req0_ctrl;
    assign sel_a    = sel ? req1_a    : req0_a;
    assign sel_b    = sel ? req1_b    : req0_b;

    alu #(.WIDTH(WIDTH)) u_alu (
        .ctrl (sel_ctrl),
        .a    (sel_a),
        .b    (sel_b),
        .y    (alu_y)
    );

    assign sel_bad    = is_bad_op(sel_ctrl);
    assign acc_result = sel_bad ? '0 : alu_y;

    always_comb begin
        last_grant_d  = last_grant_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_err_d    = rsp0_err_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_err_d    = rsp1_err_q;

        if (grant != 2'b00) begin
            last_grant_d = grant[1];
        end

        if (grant[0]) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = acc_result;
            rsp0_err_d    = sel_bad;
        end else if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        if (grant[1]) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = acc_result;
            rsp1_err_d    = sel_bad;
        end else if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q  <= 1'b1;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_err_q    <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_err_q    <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_err_q    <= rsp0_err_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_err_q    <= rsp1_err_d;
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_err    = rsp0_err_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_err    = rsp1_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected results per port,
// a monitor pops and compares whenever a result is consumed.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_err, rsp1_err;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_ctrl   (req0_ctrl),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_ctrl   (req1_ctrl),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_err    (rsp0_err),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_err    (rsp1_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed on a cycle where valid and ready are both high.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) begin
                    chk("rsp0_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("rsp0_result", rsp0_result, e.res);
                    chk("rsp0_err", {31'd0, rsp0_err}, {31'd0, e.err});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) begin
                    chk("rsp1_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("rsp1_result", rsp1_result, e.res);
                    chk("rsp1_err", {31'd0, rsp1_err}, {31'd0, e.err});
                end
            end
        end
    end

    // Drive one cycle of stimulus, check grants mid-cycle, and push expected results.
    task automatic step(
        input logic v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
        input logic v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
        input logic r0, input logic r1,
        input logic g0, input logic g1,
        input logic [31:0] e0, input logic x0,
        input logic [31:0] e1, input logic x1
    );
        req0_valid = v0; req0_ctrl = c0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_ctrl = c1; req1_a = a1; req1_b = b1;
        rsp0_ready = r0; rsp1_ready = r1;
        @(negedge clk);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
        if (g0) q0.push_back('{res: e0, err: x0});
        if (g1) q1.push_back('{res: e1, err: x1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r0, input logic r1);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, r0, r1,
             1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_ctrl = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_ctrl = 4'd0; req1_a = 32'd1; req1_b = 32'd1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("reset_rsp0_result", rsp0_result, 32'd0);
        chk("reset_rsp1_err", {31'd0, rsp1_err}, 32'd0);
        chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention: port 0 wins first, then strict alternation.
        step(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 1, 4'd3, 32'hF0, 32'h0F, 1, 1, 1, 0, 32'h0000F000, 0, 32'h0, 0);
        step(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 1, 4'd3, 32'hF0, 32'h0F, 1, 1, 0, 1, 32'h0, 0, 32'hFF, 0);
        step(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 1, 4'd3, 32'hF0, 32'h0F, 1, 1, 1, 0, 32'h0000F000, 0, 32'h0, 0);
        step(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 1, 4'd3, 32'hF0, 32'h0F, 1, 1, 0, 1, 32'h0, 0, 32'hFF, 0);

        // Single add 5+7
        step(1, 4'd0, 32'd5, 32'd7, 0, 4'd0, 32'd0, 32'd0, 1, 1, 1, 0, 32'd12, 0, 32'd0, 0);
        idle(1, 1);
        chk("rsp0_drained", {31'd0, rsp0_valid}, 32'd0);

        // Backpressure on port 0: only port 1 granted until rsp0_ready rises.
        step(1, 4'd1, 32'd10, 32'd3, 0, 4'd0, 32'd0, 32'd0, 0, 1, 1, 0, 32'd7, 0, 32'd0, 0);
        step(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 1, 4'd4, 32'd0, 32'd0, 0, 1, 0, 1, 32'd0, 0, 32'hFFFFFFFF, 0);
        step(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 1, 4'd5, 32'd3, 32'd8, 0, 1, 0, 1, 32'd0, 0, 32'd1, 0);
        step(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 1, 4'd5, 32'd3, 32'd8, 1, 1, 1, 0, 32'h0000F000, 0, 32'd0, 0);
        step(0, 4'd0, 32'd0, 32'd0, 1, 4'd5, 32'd3, 32'd8, 1, 1, 0, 1, 32'd0, 0, 32'd1, 0);

        // Invalid control code accepted with err and zero result.
        step(0, 4'd0, 32'd0, 32'd0, 1, 4'd9, 32'd1, 32'd2, 1, 1, 0, 1, 32'd0, 0, 32'd0, 1);

        // Wrap-around and unsigned compare boundaries.
        step(1, 4'd0, 32'hFFFFFFFF, 32'd2, 1, 4'd1, 32'd0, 32'd1, 1, 1, 1, 0, 32'd1, 0, 32'd0, 0);
        step(1, 4'd5, 32'hFFFFFFFF, 32'd1, 1, 4'd1, 32'd0, 32'd1, 1, 1, 0, 1, 32'd0, 0, 32'hFFFFFFFF, 0);
        step(1, 4'd5, 32'hFFFFFFFF, 32'd1, 0, 4'd0, 32'd0, 32'd0, 1, 1, 1, 0, 32'd0, 0, 32'd0, 0);

        // Port 1 result held under backpressure; new port 1 request blocked meanwhile.
        step(0, 4'd0, 32'd0, 32'd0, 1, 4'd3, 32'h12340000, 32'h00005678, 1, 0, 0, 1, 32'd0, 0, 32'h12345678, 0);
        idle(1, 0);
        chk("rsp1_held_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("rsp1_held_result", rsp1_result, 32'h12345678);
        step(0, 4'd0, 32'd0, 32'd0, 1, 4'd0, 32'd1, 32'd1, 1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
        step(0, 4'd0, 32'd0, 32'd0, 1, 4'd0, 32'd1, 32'd1, 1, 1, 0, 1, 32'd0, 0, 32'd2, 0);
        idle(1, 1);

        // Reset mid-stream with a pending port 0 result.
        step(1, 4'd0, 32'd1, 32'd1, 0, 4'd0, 32'd0, 32'd0, 0, 1, 1, 0, 32'd2, 0, 32'd0, 0);
        chk("pre_reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        req0_valid = 1'b1; req0_ctrl = 4'd2; req0_a = 32'h0000F0F0; req0_b = 32'h0000FF00;
        req1_valid = 1'b1; req1_ctrl = 4'd3; req1_a = 32'hF0;       req1_b = 32'h0F;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("midrst_rsp0_result", rsp0_result, 32'd0);
        chk("midrst_rsp0_err", {31'd0, rsp0_err}, 32'd0);
        chk("midrst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("midrst_req1_ready", {31'd0, req1_ready}, 32'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 1, 4'd3, 32'hF0, 32'h0F, 1, 1, 1, 0, 32'h0000F000, 0, 32'h0, 0);
        step(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 1, 4'd3, 32'hF0, 32'h0F, 1, 1, 0, 1, 32'h0, 0, 32'hFF, 0);
        idle(1, 1);
        idle(1, 1);

        chk("q0_empty", q0.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
